// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing constants plus the shared position type and step rule.
package vga_timing_pkg;

  localparam int COORD_W     = 10;
  localparam int FRAME_CNT_W = 8;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL_640 = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL_480 = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [COORD_W-1:0]     coord_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  // One raster advance: x wraps at h_max carrying into y, y wraps at v_max.
  function automatic pos_t pos_step(input pos_t p, input coord_t h_max, input coord_t v_max);
    pos_t n;
    n = p;
    if (p.x == h_max) begin
      n.x = '0;
      n.y = (p.y == v_max) ? '0 : p.y + coord_t'(1);
    end else begin
      n.x = p.x + coord_t'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/vga_clk_enable.sv
// Pixel-clock enable divider: one-clock advance pulse every CLK_DIV enabled clocks.
module vga_clk_enable #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic advance
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (enable) div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
  end

  assign advance = enable && (div_q == DIV_MAX);

  always_ff @(posedge clk or posedge rst)
    if (rst) div_q <= '0;
    else     div_q <= div_d;

endmodule

// File: rtl/vga_pixel_counter.sv
// Raster position counter with line/frame strobes and frame count.
// Define VGA_PREFETCH_EN to build the registered look-ahead fetch position.
module vga_pixel_counter
  import vga_timing_pkg::*;
#(
  parameter int X_RES    = 640,
  parameter int Y_RES    = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int CLK_DIV  = 1,
  parameter int PREFETCH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic [COORD_W-1:0]     pixel_position_x,
  output logic [COORD_W-1:0]     pixel_position_y,
  output logic                   pixel_tick,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [COORD_W-1:0]     fetch_x,
  output logic [COORD_W-1:0]     fetch_y,
  output logic                   fetch_active
);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || X_RES > H_TOTAL || Y_RES > V_TOTAL ||
      CLK_DIV < 1 || CLK_DIV > 16 || PREFETCH < 1 || PREFETCH > 15 || PREFETCH >= H_TOTAL)
  begin : g_cfg_err
    $error("vga_pixel_counter: parameter out of range");
  end

  localparam coord_t H_MAX = coord_t'(H_TOTAL - 1);
  localparam coord_t V_MAX = coord_t'(V_TOTAL - 1);

  logic       advance;
  pos_t       pos_q, pos_d;
  frame_cnt_t fc_q, fc_d;
  logic       tick_q, tick_d, ls_q, ls_d, fs_q, fs_d;

  vga_clk_enable #(.CLK_DIV(CLK_DIV)) u_clk_en (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .advance (advance)
  );

  always_comb begin
    pos_d  = pos_q;
    fc_d   = fc_q;
    tick_d = 1'b0;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    if (advance) begin
      pos_d  = pos_step(pos_q, H_MAX, V_MAX);
      tick_d = 1'b1;
      ls_d   = (pos_d.x == '0);
      fs_d   = ls_d && (pos_d.y == '0);
      if (fs_d) fc_d = fc_q + frame_cnt_t'(1);
    end
  end

  // Reset presents (0,0) with strobes low; the first frame_start comes from a real wrap.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pos_q  <= '0;
      fc_q   <= '0;
      tick_q <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      fc_q   <= fc_d;
      tick_q <= tick_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end

  assign pixel_position_x = pos_q.x;
  assign pixel_position_y = pos_q.y;
  assign pixel_tick       = tick_q;
  assign line_start       = ls_q;
  assign frame_start      = fs_q;
  assign frame_count      = fc_q;

`ifdef VGA_PREFETCH_EN
  localparam coord_t X_LIM     = coord_t'(X_RES);
  localparam coord_t Y_LIM     = coord_t'(Y_RES);
  localparam pos_t   FETCH_RST = '{x: coord_t'(PREFETCH), y: '0};
  localparam logic   FACT_RST  = (PREFETCH < X_RES) && (Y_RES > 0);

  pos_t fetch_q, fetch_d;
  logic fact_q, fact_d;

  // Look-ahead steps in lockstep with the position, so it stays PREFETCH advances ahead.
  always_comb begin
    fetch_d = fetch_q;
    if (advance) fetch_d = pos_step(fetch_q, H_MAX, V_MAX);
    fact_d = (fetch_d.x < X_LIM) && (fetch_d.y < Y_LIM);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_q <= FETCH_RST;
      fact_q  <= FACT_RST;
    end else begin
      fetch_q <= fetch_d;
      fact_q  <= fact_d;
    end

  assign fetch_x      = fetch_q.x;
  assign fetch_y      = fetch_q.y;
  assign fetch_active = fact_q;
`else
  assign fetch_x      = '0;
  assign fetch_y      = '0;
  assign fetch_active = 1'b0;
`endif

endmodule

// File: tb/tb_vga_pixel_counter.sv
// Bench for vga_pixel_counter: vector table, directed corners and a count-based reference model.
module tb_vga_pixel_counter;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       tick;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
    logic [9:0] fx;
    logic [9:0] fy;
    logic       fa;
  } obs_t;

  typedef struct {
    bit r;
    bit en;
    int x;
    int y;
    bit tick;
    bit ls;
    bit fs;
  } vec_t;

`ifdef VGA_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif
  localparam int PF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v[3];
  logic       en_v[3];
  logic [9:0] px[3], py[3], fxo[3], fyo[3];
  logic       tk[3], lso[3], fso[3], fao[3];
  logic [7:0] fco[3];
  obs_t       obs_v[3];

  // Instance 0: full 640x480 timing, CLK_DIV=1. 1: full timing, CLK_DIV=4. 2: tiny 10x6 raster.
  int HT[3] = '{800, 800, 10};
  int VT[3] = '{525, 525, 6};
  int XR[3] = '{640, 640, 8};
  int YR[3] = '{480, 480, 4};
  int DV[3] = '{1, 4, 1};
  int ecnt[3] = '{0, 0, 0};

  int total = 0;
  int bad   = 0;

  vga_pixel_counter #(.X_RES(640), .Y_RES(480), .H_TOTAL(800), .V_TOTAL(525), .CLK_DIV(1), .PREFETCH(PF)) u_a (
    .clk(clk), .rst(rst_v[0]), .enable(en_v[0]),
    .pixel_position_x(px[0]), .pixel_position_y(py[0]), .pixel_tick(tk[0]),
    .line_start(lso[0]), .frame_start(fso[0]), .frame_count(fco[0]),
    .fetch_x(fxo[0]), .fetch_y(fyo[0]), .fetch_active(fao[0]));

  vga_pixel_counter #(.X_RES(640), .Y_RES(480), .H_TOTAL(800), .V_TOTAL(525), .CLK_DIV(4), .PREFETCH(PF)) u_b (
    .clk(clk), .rst(rst_v[1]), .enable(en_v[1]),
    .pixel_position_x(px[1]), .pixel_position_y(py[1]), .pixel_tick(tk[1]),
    .line_start(lso[1]), .frame_start(fso[1]), .frame_count(fco[1]),
    .fetch_x(fxo[1]), .fetch_y(fyo[1]), .fetch_active(fao[1]));

  vga_pixel_counter #(.X_RES(8), .Y_RES(4), .H_TOTAL(10), .V_TOTAL(6), .CLK_DIV(1), .PREFETCH(PF)) u_c (
    .clk(clk), .rst(rst_v[2]), .enable(en_v[2]),
    .pixel_position_x(px[2]), .pixel_position_y(py[2]), .pixel_tick(tk[2]),
    .line_start(lso[2]), .frame_start(fso[2]), .frame_count(fco[2]),
    .fetch_x(fxo[2]), .fetch_y(fyo[2]), .fetch_active(fao[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs_v[g] = {px[g], py[g], tk[g], lso[g], fso[g], fco[g], fxo[g], fyo[g], fao[g]};
  end

  // Everything follows from the number of enabled clocks since reset.
  function automatic obs_t model(input int id, input bit adv);
    obs_t o;
    int   n, m;
    o = '0;
    n = ecnt[id] / DV[id];
    o.x    = 10'(n % HT[id]);
    o.y    = 10'((n / HT[id]) % VT[id]);
    o.fc   = 8'((n / (HT[id] * VT[id])) % 256);
    o.tick = adv;
    o.ls   = adv && (o.x == 10'd0);
    o.fs   = o.ls && (o.y == 10'd0);
    if (PF_EN) begin
      m = n + PF;
      o.fx = 10'(m % HT[id]);
      o.fy = 10'((m / HT[id]) % VT[id]);
      o.fa = (int'(o.fx) < XR[id]) && (int'(o.fy) < YR[id]);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d tick=%0d ls=%0d fs=%0d fc=%0d fx=%0d fy=%0d fa=%0d ; want x=%0d y=%0d tick=%0d ls=%0d fs=%0d fc=%0d fx=%0d fy=%0d fa=%0d",
               nm, act.x, act.y, act.tick, act.ls, act.fs, act.fc, act.fx, act.fy, act.fa,
               exp.x, exp.y, exp.tick, exp.ls, exp.fs, exp.fc, exp.fx, exp.fy, exp.fa);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic cyc(input int id, input bit r, input bit en);
    bit adv;
    rst_v[id] = r;
    en_v[id]  = en;
    @(posedge clk);
    adv = 1'b0;
    if (r) ecnt[id] = 0;
    else if (en) begin
      ecnt[id]++;
      adv = (ecnt[id] % DV[id]) == 0;
    end
    @(negedge clk);
    chk($sformatf("model%0d e=%0d", id, ecnt[id]), obs_v[id], model(id, adv));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    int   nt, nl;
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1;
      en_v[i]  = 1'b0;
    end

    // ---- vector table on the tiny raster ----
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 2, 0, 1, 0, 0};
    for (int i = 5; i < 12; i++) tbl[i] = '{0, 1, i - 2, 0, 1, 0, 0};
    tbl[12] = '{0, 1, 0, 1, 1, 1, 0};
    tbl[13] = '{0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      cyc(2, tbl[i].r, tbl[i].en);
      chk_int($sformatf("vec%0d.x", i), int'(px[2]), tbl[i].x);
      chk_int($sformatf("vec%0d.y", i), int'(py[2]), tbl[i].y);
      chk_int($sformatf("vec%0d.strobes", i), int'({tk[2], lso[2], fso[2]}),
              int'({tbl[i].tick, tbl[i].ls, tbl[i].fs}));
    end

    // ---- random enable/reset against the model ----
    for (int i = 0; i < 2000; i++)
      cyc(2, $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);

    // ---- 256 frames on the tiny raster: prefetch corners and frame_count wrap ----
    cyc(2, 1'b1, 1'b0);
    for (int k = 1; k <= 256 * 60; k++) begin
      cyc(2, 1'b0, 1'b1);
      if (k == 38) begin
        chk_int("pf_visedge.pos", int'({px[2], py[2]}), int'({10'd8, 10'd3}));
        chk_int("pf_visedge.fetch", int'({fxo[2], fyo[2]}), PF_EN ? int'({10'd0, 10'd4}) : 0);
        chk_int("pf_visedge.active", int'(fao[2]), 0);
      end
      if (k == 59) begin
        chk_int("pf_framend.pos", int'({px[2], py[2]}), int'({10'd9, 10'd5}));
        chk_int("pf_framend.fetch", int'({fxo[2], fyo[2]}), PF_EN ? int'({10'd1, 10'd0}) : 0);
        chk_int("pf_framend.active", int'(fao[2]), PF_EN ? 1 : 0);
      end
      if (k == 60) chk_int("first_frame.fs_fc", int'({fso[2], fco[2]}), int'({1'b1, 8'd1}));
      if (k == 255 * 60) chk_int("fc255", int'(fco[2]), 255);
      if (k == 256 * 60)
        chk_int("fc_wrap", int'({px[2], py[2], tk[2], lso[2], fso[2], fco[2]}),
                int'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0}));
    end
    rst_v[2] = 1'b1;

    // ---- full raster, CLK_DIV=1: line wrap and async reset mid-frame ----
    cyc(0, 1'b1, 1'b0);
    for (int i = 0; i < 500; i++) cyc(0, 1'b0, $urandom_range(0, 1) == 1);
    while (ecnt[0] < 10 * 800 + 799) cyc(0, 1'b0, 1'b1);
    chk_int("linewrap.pre", int'({px[0], py[0]}), int'({10'd799, 10'd10}));
    cyc(0, 1'b0, 1'b1);
    chk_int("linewrap.post", int'({px[0], py[0], tk[0], lso[0], fso[0]}),
            int'({10'd0, 10'd11, 1'b1, 1'b1, 1'b0}));
    while (ecnt[0] < 45 * 800 + 123) cyc(0, 1'b0, 1'b1);
    chk_int("rst.pre", int'({px[0], py[0], tk[0]}), int'({10'd123, 10'd45, 1'b1}));
    #2;
    rst_v[0] = 1'b1;
    #1;
    chk_int("rst.async.pos_strobes", int'({px[0], py[0], tk[0], lso[0], fso[0], fco[0]}), 0);
    chk_int("rst.async.fetch", int'({fxo[0], fyo[0], fao[0]}),
            PF_EN ? int'({10'd2, 10'd0, 1'b1}) : 0);
    ecnt[0] = 0;
    @(negedge clk);
    cyc(0, 1'b0, 1'b1);
    chk_int("rst.first_adv", int'({px[0], py[0], tk[0], fso[0]}), int'({10'd1, 10'd0, 1'b1, 1'b0}));
    rst_v[0] = 1'b1;

    // ---- full raster, CLK_DIV=4: tick rate, then enable gating with divider at 2 ----
    cyc(1, 1'b1, 1'b0);
    nt = 0;
    nl = 0;
    for (int i = 0; i < 3200; i++) begin
      cyc(1, 1'b0, 1'b1);
      nt += int'(tk[1]);
      nl += int'(lso[1]);
    end
    chk_int("div4.ticks", nt, 800);
    chk_int("div4.line_starts", nl, 1);
    while (ecnt[1] < 4402) cyc(1, 1'b0, 1'b1);
    chk_int("gate.pre", int'({px[1], py[1]}), int'({10'd300, 10'd1}));
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1'b0, 1'b0);
      chk_int($sformatf("gate.hold%0d", i), int'({px[1], py[1], tk[1], lso[1], fso[1]}),
              int'({10'd300, 10'd1, 3'b000}));
    end
    cyc(1, 1'b0, 1'b1);
    chk_int("gate.resume1", int'({px[1], tk[1]}), int'({10'd300, 1'b0}));
    cyc(1, 1'b0, 1'b1);
    chk_int("gate.resume2", int'({px[1], py[1], tk[1]}), int'({10'd301, 10'd1, 1'b1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
